// File: rtl/video_core_out_fifo.sv
// Output pixel FIFO between the video pipeline and the VGA timing block; reports underflow.
// Optional underflow counter enabled by defining VIDEO_FIFO_UFLOW_CNT_EN.
package video_core_pkg;
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic sof;
    } vga_fc_t;
endpackage

module video_core_out_fifo
    import video_core_pkg::*;
#(
    parameter int RGB_SIZE = 12,
    parameter int DEPTH    = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_in_vld,
    output logic                fifo_in_rdy,
    input  vga_fc_t             fifo_in_fc,
    input  logic [RGB_SIZE-1:0] fifo_in_rgb,
    input  logic                vga_rd,
    output logic                vga_vld,
    output vga_fc_t             vga_fc,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic [AW:0]         fifo_level,
    output logic                uflow,
    input  logic                uflow_clr,
    output logic [15:0]         uflow_cnt
);
    localparam int FCW = $bits(vga_fc_t);
    localparam int EW  = FCW + RGB_SIZE;

    logic [EW-1:0]       mem_r [DEPTH];
    logic [AW:0]         wr_ptr_r, rd_ptr_r, level_r;
    logic [AW:0]         wr_nxt_s, rd_nxt_s;
    logic                empty_s, full_s, rdy_s, push_s, pop_s, uflow_ev_s;
    logic [EW-1:0]       rd_entry_s;
    logic                vga_vld_r, uflow_r;
    vga_fc_t             vga_fc_r;
    logic [RGB_SIZE-1:0] vga_rgb_r;
    logic [15:0]         uflow_cnt_s;

    // Flags and handshakes derived from registered pointers only; ready is held low during reset.
    always_comb begin
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        rdy_s      = !rst && !full_s;
        push_s     = fifo_in_vld && rdy_s;
        pop_s      = vga_rd && !empty_s;
        uflow_ev_s = vga_rd && empty_s;
        rd_entry_s = mem_r[rd_ptr_r[AW-1:0]];
        if (push_s) begin
            wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {fifo_in_fc, fifo_in_rgb};
        end
    end

    // Pointers and occupancy move together so the level always matches wr_ptr - rd_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            level_r  <= wr_nxt_s - rd_nxt_s;
        end
    end

    // Read port: popped data, black on underflow, otherwise hold the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_vld_r <= 1'b0;
            vga_rgb_r <= '0;
            vga_fc_r  <= '0;
        end else if (pop_s) begin
            vga_vld_r <= 1'b1;
            vga_rgb_r <= rd_entry_s[RGB_SIZE-1:0];
            vga_fc_r  <= rd_entry_s[EW-1:RGB_SIZE];
        end else if (uflow_ev_s) begin
            vga_vld_r <= 1'b0;
            vga_rgb_r <= '0;
            vga_fc_r  <= '0;
        end else begin
            vga_vld_r <= 1'b0;
        end
    end

    // Sticky underflow flag; a new underflow outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uflow_r <= 1'b0;
        end else if (uflow_ev_s) begin
            uflow_r <= 1'b1;
        end else if (uflow_clr) begin
            uflow_r <= 1'b0;
        end else begin
            uflow_r <= uflow_r;
        end
    end

`ifdef VIDEO_FIFO_UFLOW_CNT_EN
    logic [15:0] uflow_cnt_r;

    // Saturating underflow counter; clear outranks increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uflow_cnt_r <= 16'h0000;
        end else if (uflow_clr) begin
            uflow_cnt_r <= 16'h0000;
        end else if (uflow_ev_s && (uflow_cnt_r != 16'hFFFF)) begin
            uflow_cnt_r <= uflow_cnt_r + 16'h0001;
        end else begin
            uflow_cnt_r <= uflow_cnt_r;
        end
    end

    assign uflow_cnt_s = uflow_cnt_r;
`else
    assign uflow_cnt_s = 16'h0000;
`endif

    assign fifo_in_rdy = rdy_s;
    assign vga_vld     = vga_vld_r;
    assign vga_rgb     = vga_rgb_r;
    assign vga_fc      = vga_fc_r;
    assign fifo_level  = level_r;
    assign uflow       = uflow_r;
    assign uflow_cnt   = uflow_cnt_s;
endmodule

// File: tb/tb_video_core_out_fifo.sv
// Self-checking bench for video_core_out_fifo: queue-based reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_video_core_out_fifo;
    import video_core_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_in_vld;
    logic        fifo_in_rdy;
    vga_fc_t     fifo_in_fc;
    logic [11:0] fifo_in_rgb;
    logic        vga_rd;
    logic        vga_vld;
    vga_fc_t     vga_fc;
    logic [11:0] vga_rgb;
    logic [4:0]  fifo_level;
    logic        uflow;
    logic        uflow_clr;
    logic [15:0] uflow_cnt;

    video_core_out_fifo #(.RGB_SIZE(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .fifo_in_vld(fifo_in_vld), .fifo_in_rdy(fifo_in_rdy),
        .fifo_in_fc(fifo_in_fc), .fifo_in_rgb(fifo_in_rgb),
        .vga_rd(vga_rd), .vga_vld(vga_vld), .vga_fc(vga_fc), .vga_rgb(vga_rgb),
        .fifo_level(fifo_level), .uflow(uflow), .uflow_clr(uflow_clr), .uflow_cnt(uflow_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of {fc, rgb} plus the visible output state.
    logic [15:0] q[$];
    logic        m_vld;
    logic [11:0] m_rgb;
    logic [3:0]  m_fc;
    logic        m_uflow;
    int          m_cnt;

    typedef struct {
        logic        vld;
        logic [3:0]  fc;
        logic [11:0] rgb;
        logic        rd;
        logic        clr;
        logic        e_vld;
        logic [11:0] e_rgb;
        logic [4:0]  e_lvl;
        logic        e_uflow;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vld = 1'b0; m_rgb = 12'h000; m_fc = 4'h0; m_uflow = 1'b0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] fc_v;
        fc_v = vga_fc;
        chk({tag, ".vld"},   {31'b0, vga_vld}, {31'b0, m_vld});
        chk({tag, ".rgb"},   {20'b0, vga_rgb}, {20'b0, m_rgb});
        chk({tag, ".fc"},    {28'b0, fc_v}, {28'b0, m_fc});
        chk({tag, ".level"}, {27'b0, fifo_level}, q.size());
        chk({tag, ".rdy"},   {31'b0, fifo_in_rdy}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".uflow"}, {31'b0, uflow}, {31'b0, m_uflow});
`ifdef VIDEO_FIFO_UFLOW_CNT_EN
        chk({tag, ".cnt"},   {16'b0, uflow_cnt}, m_cnt);
`else
        chk({tag, ".cnt"},   {16'b0, uflow_cnt}, 32'd0);
`endif
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
    task automatic cyc(input logic vld, input logic [3:0] fc, input logic [11:0] rgb,
                       input logic rd, input logic clr, input string tag);
        bit rdy_now;
        bit uf;
        logic [15:0] e;
        fifo_in_vld = vld; fifo_in_fc = fc; fifo_in_rgb = rgb; vga_rd = rd; uflow_clr = clr;
        rdy_now = (q.size() < DEPTH);
        uf = 1'b0;
        if (rd && q.size() > 0) begin
            e = q.pop_front();
            m_vld = 1'b1; m_fc = e[15:12]; m_rgb = e[11:0];
        end else if (rd) begin
            uf = 1'b1;
            m_vld = 1'b0; m_fc = 4'h0; m_rgb = 12'h000;
        end else begin
            m_vld = 1'b0;
        end
        if (vld && rdy_now) q.push_back({fc, rgb});
        if (uf) m_uflow = 1'b1;
        else if (clr) m_uflow = 1'b0;
        if (clr) m_cnt = 0;
        else if (uf && m_cnt < 65535) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'h1, 12'hABC, 1'b1, 1'b0, 1'b0, 12'h000, 5'd1, 1'b1};
        tbl[1] = '{1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b1, 12'hABC, 5'd0, 1'b1};
        tbl[2] = '{1'b0, 4'h0, 12'h000, 1'b0, 1'b1, 1'b0, 12'hABC, 5'd0, 1'b0};
        tbl[3] = '{1'b1, 4'h2, 12'h123, 1'b0, 1'b0, 1'b0, 12'hABC, 5'd1, 1'b0};
        tbl[4] = '{1'b1, 4'h3, 12'h456, 1'b1, 1'b0, 1'b1, 12'h123, 5'd1, 1'b0};
        tbl[5] = '{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h456, 5'd0, 1'b0};
        tbl[6] = '{1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 5'd0, 1'b1};
        tbl[7] = '{1'b0, 4'h0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};

        rst = 1'b1; fifo_in_vld = 1'b0; fifo_in_fc = '0; fifo_in_rgb = 12'h000;
        vga_rd = 1'b0; uflow_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset.rdy", {31'b0, fifo_in_rdy}, 32'd0);
        chk("reset.level", {27'b0, fifo_level}, 32'd0);
        chk("reset.vld", {31'b0, vga_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release.rdy", {31'b0, fifo_in_rdy}, 32'd1);
        @(posedge clk); #1;

        // Fill to full, then try a 17th push which must be held off.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, i[3:0], 12'(i + 1), 1'b0, 1'b0, "fill");
        chk("full.level", {27'b0, fifo_level}, 32'd16);
        chk("full.rdy", {31'b0, fifo_in_rdy}, 32'd0);
        cyc(1'b1, 4'hF, 12'h011, 1'b0, 1'b0, "push17");

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 4'h0, 12'h000, 1'b1, 1'b0, "drain");
            chk("drain.order", {20'b0, vga_rgb}, i + 1);
        end
        chk("drain.level", {27'b0, fifo_level}, 32'd0);

        // Underflow and clear.
        cyc(1'b0, 4'h0, 12'h000, 1'b1, 1'b0, "uflow");
        chk("uflow.flag", {31'b0, uflow}, 32'd1);
        cyc(1'b0, 4'h0, 12'h000, 1'b0, 1'b1, "uclr");
        chk("uclr.flag", {31'b0, uflow}, 32'd0);

        // Steady push+pop at level 8.
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'h5, 12'(12'h100 + i), 1'b0, 1'b0, "pre8");
        for (int i = 0; i < 100; i++)
            cyc(1'b1, 4'(i), 12'(12'h200 + i), 1'b1, 1'b0, "lvl8");
        chk("lvl8.level", {27'b0, fifo_level}, 32'd8);
        chk("lvl8.uflow", {31'b0, uflow}, 32'd0);

        // Full with simultaneous push and pop: pop only, level DEPTH-1.
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'h6, 12'(12'h300 + i), 1'b0, 1'b0, "top");
        cyc(1'b1, 4'h7, 12'h3FF, 1'b1, 1'b0, "fullpp");
        chk("fullpp.level", {27'b0, fifo_level}, 32'd15);

        // Mid-stream async reset at level 5 with nonzero outputs.
        while (q.size() > 6) cyc(1'b0, 4'h0, 12'h000, 1'b1, 1'b0, "down");
        cyc(1'b0, 4'h0, 12'h000, 1'b1, 1'b0, "to5");
        chk("pre_rst.level", {27'b0, fifo_level}, 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("async.vld", {31'b0, vga_vld}, 32'd0);
        chk("async.rgb", {20'b0, vga_rgb}, 32'd0);
        chk("async.level", {27'b0, fifo_level}, 32'd0);
        chk("async.rdy", {31'b0, fifo_in_rdy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel.rdy", {31'b0, fifo_in_rdy}, 32'd1);
        chk("rst_rel.level", {27'b0, fifo_level}, 32'd0);

        // Vector table: empty push+pop, hold, set-wins-over-clear.
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].vld, tbl[i].fc, tbl[i].rgb, tbl[i].rd, tbl[i].clr, "tbl");
            chk($sformatf("tbl%0d.vld", i), {31'b0, vga_vld}, {31'b0, tbl[i].e_vld});
            chk($sformatf("tbl%0d.rgb", i), {20'b0, vga_rgb}, {20'b0, tbl[i].e_rgb});
            chk($sformatf("tbl%0d.lvl", i), {27'b0, fifo_level}, {27'b0, tbl[i].e_lvl});
            chk($sformatf("tbl%0d.uflow", i), {31'b0, uflow}, {31'b0, tbl[i].e_uflow});
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 60, 4'($urandom), 12'($urandom),
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5, "rand");
        end

        fifo_in_vld = 1'b0; vga_rd = 1'b0; uflow_clr = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/video_core_out_fifo.md
# video_core_out_fifo

Output buffer at the tail of the video core. It accepts the valid/ready pixel stream (frame-control plus RGB) from the last pipeline stage and stores it in a synchronous FIFO. It returns pixels one per request to the VGA sync/timing block, which pulls at the fixed pixel rate. This decouples pipeline back-pressure from raster timing, and the block detects and reports underflow.

## Interface
- `RGB_SIZE`, 12: pixel colour width.
- `DEPTH`, 16: FIFO entries; must be a power of two and at least 4.
- `AW`, $clog2(DEPTH): address width (derived; do not override).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `fifo_in_vld` in 1: upstream pixel valid.
- `fifo_in_rdy` out 1: FIFO can accept.
- `fifo_in_fc` in vga_fc_t: frame-control word, stored opaquely.
- `fifo_in_rgb` in RGB_SIZE: pixel.
- `vga_rd` in 1: pixel request from the VGA timing block, one per active-video pixel.
- `vga_vld` out 1: `vga_rgb`/`vga_fc` hold popped data this cycle.
- `vga_fc` out vga_fc_t: popped frame-control.
- `vga_rgb` out RGB_SIZE: popped pixel; 0 (black) on underflow.
- `fifo_level` out AW+1: current occupancy, 0..DEPTH.
- `uflow` out 1: sticky underflow flag.
- `uflow_clr` in 1: clears `uflow` (and the counter, if present).
- `uflow_cnt` out 16: underflow count (see Configuration).

## Operation
- Storage: DEPTH-entry array of {fc, rgb}. Write and read pointers are AW+1 bits.
  - empty = pointers equal.
  - full = addresses equal and MSBs differ.
  - `fifo_level` = wr_ptr − rd_ptr, registered consistent with the pointers.
- Push: `fifo_in_vld && fifo_in_rdy` writes to mem[wr_ptr[AW-1:0]], and wr_ptr increments with natural wrap.
- `fifo_in_rdy` = !full; it is forced 0 while `rst` is asserted.
- Pop: `vga_rd && !empty` reads mem[rd_ptr], and rd_ptr increments.
  - Next cycle: `vga_vld`=1, `vga_rgb`/`vga_fc` = entry.
- Underflow: `vga_rd && empty`. Next cycle:
  - `vga_vld`=0, `vga_rgb`=0, `vga_fc`='0;
  - `uflow` set.
- No request: `vga_rd`=0. Next cycle `vga_vld`=0; `vga_rgb`/`vga_fc` hold their last value.
- Simultaneous push and pop:
  - When not empty and not full, both happen and the level is unchanged.
  - When empty, the pop underflows; the push is stored; level becomes 1. There is no write-to-read bypass.
  - When full, the pop happens; the push is blocked because rdy=0 this cycle; level becomes DEPTH−1.
- `uflow_clr` clears `uflow`. If an underflow occurs in the same cycle, set wins: `uflow` stays 1.
- Reset mid-operation discards all contents.
  - Pointers, level, `vga_vld`, `vga_rgb`, `vga_fc`, `uflow` and `uflow_cnt` go to 0.
  - `fifo_in_rdy` returns to 1 after `rst` deasserts.

## Timing
- Read latency: 1 cycle from `vga_rd` to `vga_vld`/`vga_rgb`.
- Write-to-readable latency: an entry pushed in cycle N can be popped by `vga_rd` in cycle N+1. Its data appears in N+2.
- `fifo_in_rdy` depends only on registered state. There is no combinational path from `vga_rd` to `fifo_in_rdy`.
- Throughput is one push and one pop per cycle, sustained.
- Reset values of all outputs are 0, except `fifo_in_rdy`, which is 0 during reset and 1 after.

## Configuration
- `VIDEO_FIFO_UFLOW_CNT_EN` defined:
  - `uflow_cnt` is a 16-bit counter that increments on each underflow cycle and saturates at 16'hFFFF.
  - `uflow_clr` zeroes it; clear wins over increment in the same cycle.
- Not defined: no counter logic; `uflow_cnt` is tied to 0. The sticky `uflow` flag is always present.

## Test plan
- Reset, then push 16 pixels rgb 0x001..0x010 with `vga_rd`=0:
  - `fifo_level`=16 and `fifo_in_rdy`=0;
  - the 17th `fifo_in_vld` is held off.
- From full, assert `vga_rd` for 16 cycles:
  - `vga_vld`=1 each following cycle, in order 0x001..0x010 with matching fc;
  - then `fifo_level`=0.
- `vga_rd` with the FIFO empty:
  - next cycle `vga_vld`=0, `vga_rgb`=0, `uflow`=1;
  - `uflow_cnt`=1 with the macro, 0 without;
  - `uflow_clr` then returns both to 0.
- Continuous push and pop at level 8 for 100 cycles: level stays 8, data stays in order, `uflow`=0.
- Push and pop in the same cycle on an empty FIFO: underflow is reported, level becomes 1, and the next `vga_rd` returns that pixel.
- Assert `rst` mid-stream at level 5: all outputs are 0 immediately (async); after release, level=0 and `fifo_in_rdy`=1.
